// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache.
// - state_t     : controller states (IDLE, miss handling, flush walk)
// - OFF_W/IDX_W/TAG_W/WSEL_W : address split for the default geometry
//                 (32-bit address, 256-bit lines, 32 sets, 32-bit words)
// - tag_entry_t : per-line bookkeeping {valid, dirty, tag} for that geometry
// Modules that take other geometries derive their own widths from their
// parameters; the values here document the default build.
package dcache_pkg;

  localparam int OFF_W  = 5;
  localparam int IDX_W  = 5;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WSEL_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WB,
    S_REFILL,
    S_REFILL_OK,
    S_FL_SCAN,
    S_FL_WB,
    S_FL_DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/dcache_way_ram.sv
// One way of the cache: SETS entries of {line, tag, valid, dirty}.
// Reads are asynchronous at idx; writes happen on the rising edge.
// Ports:
//   clk, rst        clock, async active-high reset (clears valid/dirty only)
//   idx             set index shared by read and write
//   line_we         full-line fill: line_wdata/tag_wdata, valid=1, dirty=0
//   word_we         single-word store at word_sel, sets dirty
//   dirty_clr       clears dirty after a flush write-back
//   rd_*            current contents of entry idx
module dcache_way_ram #(
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  parameter int TAG_W  = 22,
  parameter int SETS   = 32,
  localparam int IDX_BITS  = $clog2(SETS),
  localparam int WSEL_BITS = $clog2(LINE_W / WORD_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_BITS-1:0]  idx,
  input  logic                 line_we,
  input  logic [LINE_W-1:0]    line_wdata,
  input  logic [TAG_W-1:0]     tag_wdata,
  input  logic                 word_we,
  input  logic [WSEL_BITS-1:0] word_sel,
  input  logic [WORD_W-1:0]    word_wdata,
  input  logic                 dirty_clr,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_W-1:0]    rd_line
);

  logic [LINE_W-1:0] line_q [SETS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = line_q[idx];

  // Payload storage carries no reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_q[idx] <= line_wdata;
      tag_q[idx]  <= tag_wdata;
    end else if (word_we) begin
      line_q[idx][word_sel*WORD_W +: WORD_W] <= word_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end else if (dirty_clr) begin
      dirty_q[idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/dcache_assoc_top.sv
// N-way set-associative, write-back, write-allocate data cache.
// CPU side (p1_*): word reads/writes, zero-wait on hit, stall on miss.
// Memory side (mem_*): one line-wide transaction at a time, request held
// until mem_ack_i; address/data registered and changed only at a launch.
// flush_i (pulse, honoured in IDLE) writes back every dirty line, walking
// {set, way} upward, and pulses flush_done_o when finished.
// Victim: lowest invalid way, else the per-set round-robin pointer.
//
// Memory handshake: mem_enable_o rises with a launch and stays high until a
// cycle with mem_ack_i; mem_write_o/mem_addr_o/mem_data_o are stable for the
// whole request; mem_ack_i is ignored while mem_enable_o is low.
module dcache_assoc_top
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic              flush_i,
  output logic              flush_done_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam int OFF_BITS  = $clog2(LINE_W / 8);
  localparam int IDX_BITS  = $clog2(SETS);
  localparam int TAG_BITS  = ADDR_W - IDX_BITS - OFF_BITS;
  localparam int WSEL_BITS = $clog2(LINE_W / WORD_W);
  localparam int BSEL_BITS = $clog2(WORD_W / 8);
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t state_q, state_d;

  logic [TAG_BITS-1:0]  p_tag;
  logic [IDX_BITS-1:0]  p_idx;
  logic [WSEL_BITS-1:0] p_wsel;
  logic [BSEL_BITS-1:0] addr_unused;
  logic                 req, ack, flushing;

  assign p_tag       = p1_addr_i[ADDR_W-1 -: TAG_BITS];
  assign p_idx       = p1_addr_i[OFF_BITS +: IDX_BITS];
  assign p_wsel      = p1_addr_i[BSEL_BITS +: WSEL_BITS];
  assign addr_unused = p1_addr_i[BSEL_BITS-1:0];
  assign req         = p1_MemRead_i | p1_MemWrite_i;
  assign ack         = mem_ack_i & mem_enable_o;
  assign flushing    = (state_q == S_FL_SCAN) || (state_q == S_FL_WB);

  // Flush walker position and per-set victim pointers.
  logic [IDX_BITS-1:0] fl_set_q;
  logic [WAY_BITS-1:0] fl_way_q;
  logic                fl_last, fl_start, fl_step;
  logic [WAY_BITS-1:0] vptr_q [SETS];
  logic                vptr_inc;

  assign fl_last = (fl_set_q == IDX_BITS'(SETS - 1)) && (fl_way_q == WAY_BITS'(WAYS - 1));

  // All ways look at one set: the flush walker's while flushing, else the CPU's.
  logic [IDX_BITS-1:0] idx;
  assign idx = flushing ? fl_set_q : p_idx;

  logic [WAYS-1:0]     way_valid, way_dirty;
  logic [TAG_BITS-1:0] way_tag  [WAYS];
  logic [LINE_W-1:0]   way_line [WAYS];
  logic [WAYS-1:0]     line_we, word_we, dirty_clr;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way_ram #(
      .LINE_W(LINE_W), .WORD_W(WORD_W), .TAG_W(TAG_BITS), .SETS(SETS)
    ) u_way (
      .clk        (clk_i),
      .rst        (rst_i),
      .idx        (idx),
      .line_we    (line_we[w]),
      .line_wdata (mem_data_i),
      .tag_wdata  (p_tag),
      .word_we    (word_we[w]),
      .word_sel   (p_wsel),
      .word_wdata (p1_data_i),
      .dirty_clr  (dirty_clr[w]),
      .rd_valid   (way_valid[w]),
      .rd_dirty   (way_dirty[w]),
      .rd_tag     (way_tag[w]),
      .rd_line    (way_line[w])
    );
  end

  // Hit detection and victim choice for the CPU's set.
  logic                hit, vfound;
  logic [WAY_BITS-1:0] hit_way, victim;
  logic [LINE_W-1:0]   hit_line;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vfound  = 1'b0;
    victim  = vptr_q[p_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == p_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!vfound && !way_valid[w]) begin
        vfound = 1'b1;
        victim = WAY_BITS'(w);
      end
    end
  end

  assign hit_line     = way_line[hit_way];
  assign p1_data_o    = (state_q == S_IDLE && p1_MemRead_i && hit) ?
                        hit_line[p_wsel*WORD_W +: WORD_W] : '0;
  assign p1_stall_o   = (req && !hit) || (state_q != S_IDLE);
  assign flush_done_o = (state_q == S_FL_DONE);

  // Launch request towards memory, captured by the mem_* registers.
  logic              launch, launch_we;
  logic [ADDR_W-1:0] launch_addr;
  logic [LINE_W-1:0] launch_data;
  logic [ADDR_W-1:0] refill_addr;

  assign refill_addr = {p_tag, p_idx, {OFF_BITS{1'b0}}};

  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    launch_we   = 1'b0;
    launch_addr = '0;
    launch_data = '0;
    line_we     = '0;
    word_we     = '0;
    dirty_clr   = '0;
    vptr_inc    = 1'b0;
    fl_start    = 1'b0;
    fl_step     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p1_MemWrite_i && hit) word_we[hit_way] = 1'b1;
        if (flush_i) begin
          state_d  = S_FL_SCAN;
          fl_start = 1'b1;
        end else if (req && !hit) begin
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        launch = 1'b1;
        if (way_valid[victim] && way_dirty[victim]) begin
          launch_we   = 1'b1;
          launch_addr = {way_tag[victim], p_idx, {OFF_BITS{1'b0}}};
          launch_data = way_line[victim];
          state_d     = S_WB;
        end else begin
          launch_addr = refill_addr;
          state_d     = S_REFILL;
        end
      end
      S_WB: begin
        if (ack) begin
          launch      = 1'b1;
          launch_addr = refill_addr;
          state_d     = S_REFILL;
        end
      end
      S_REFILL: begin
        if (ack) begin
          line_we[victim] = 1'b1;
          vptr_inc        = 1'b1;
          state_d         = S_REFILL_OK;
        end
      end
      S_REFILL_OK: state_d = S_IDLE;
      S_FL_SCAN: begin
        if (way_dirty[fl_way_q]) begin
          launch      = 1'b1;
          launch_we   = 1'b1;
          launch_addr = {way_tag[fl_way_q], fl_set_q, {OFF_BITS{1'b0}}};
          launch_data = way_line[fl_way_q];
          state_d     = S_FL_WB;
        end else begin
          fl_step = 1'b1;
          state_d = fl_last ? S_FL_DONE : S_FL_SCAN;
        end
      end
      S_FL_WB: begin
        if (ack) begin
          dirty_clr[fl_way_q] = 1'b1;
          fl_step             = 1'b1;
          state_d             = fl_last ? S_FL_DONE : S_FL_SCAN;
        end
      end
      S_FL_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else if (launch) begin
      mem_enable_o <= 1'b1;
      mem_write_o  <= launch_we;
      mem_addr_o   <= launch_addr;
      if (launch_we) mem_data_o <= launch_data;
    end else if (ack) begin
      mem_enable_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fl_set_q <= '0;
      fl_way_q <= '0;
    end else if (fl_start) begin
      fl_set_q <= '0;
      fl_way_q <= '0;
    end else if (fl_step) begin
      if (fl_way_q == WAY_BITS'(WAYS - 1)) begin
        fl_way_q <= '0;
        fl_set_q <= fl_set_q + 1'b1;
      end else begin
        fl_way_q <= fl_way_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) vptr_q[s] <= '0;
    end else if (vptr_inc) begin
      vptr_q[p_idx] <= (vptr_q[p_idx] == WAY_BITS'(WAYS - 1)) ? '0 : vptr_q[p_idx] + 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_assoc_top.sv
// Directed + randomized bench for dcache_assoc_top (default geometry).
// Reference model: architectural memory (latest CPU write per word) plus a
// residency table per set (valid/tag/dirty per way, round-robin pointer)
// used to predict hits, victims, write-backs and stall lengths.
module tb_dcache_assoc_top;

  localparam int ADDR_W = 32, WORD_W = 32, LINE_W = 256, SETS = 32, WAYS = 2;
  localparam int LAT = 4;
  localparam int STALL_MAX = 100;
  localparam int FLUSH_MAX = 2000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] p1_addr_i = '0;
  logic [WORD_W-1:0] p1_data_i = '0;
  logic              p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0;
  logic [WORD_W-1:0] p1_data_o;
  logic              p1_stall_o;
  logic              flush_i = 1'b0;
  logic              flush_done_o;
  logic [LINE_W-1:0] mem_data_i = '0;
  logic              mem_ack_i = 1'b0;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o, mem_write_o;

  always #5 clk = ~clk;

  dcache_assoc_top #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
  );

  int total = 0;
  int bad = 0;

  // ---------------- memory + reference model state ----------------
  logic [LINE_W-1:0] mem_lines [logic [31:0]];
  logic [31:0]       arch_w    [logic [31:0]];
  logic [31:0]       wb_addr_q[$];
  logic [LINE_W-1:0] wb_data_q[$];
  logic [31:0]       rf_addr_q[$];
  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  logic [31:0]       m_tag   [SETS][WAYS];
  int                m_ptr   [SETS];
  logic [31:0]       last_rdata;
  int                mem_cnt = 0;

  function automatic logic [LINE_W-1:0] init_line(input logic [31:0] lad);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = ((lad + 32'(i*4)) * 32'h9E37_79B1) ^ 32'h1234_5678;
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] lad);
    if (mem_lines.exists(lad)) return mem_lines[lad];
    return init_line(lad);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [LINE_W-1:0] l;
    l = mem_line(addr & ~32'h1f);
    return l[addr[4:2]*32 +: 32];
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] addr);
    logic [31:0] a;
    a = addr & ~32'h3;
    if (arch_w.exists(a)) return arch_w[a];
    return mem_word(a);
  endfunction

  function automatic logic [LINE_W-1:0] arch_line(input logic [31:0] lad);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = arch_rd(lad + 32'(i*4));
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0;
      end
    end
  endtask

  // Memory: ack in the LAT-th cycle that a request is seen.
  always @(negedge clk) begin
    if (mem_enable_o === 1'b1) begin
      mem_cnt++;
      if (mem_cnt == LAT) begin
        if (mem_write_o) begin
          mem_lines[mem_addr_o] = mem_data_o;
          wb_addr_q.push_back(mem_addr_o);
          wb_data_q.push_back(mem_data_o);
        end else begin
          mem_data_i = mem_line(mem_addr_o);
          rf_addr_q.push_back(mem_addr_o);
        end
        mem_ack_i = 1'b1;
        mem_cnt = 0;
      end else begin
        mem_ack_i = 1'b0;
      end
    end else begin
      mem_ack_i = 1'b0;
      mem_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- CPU transaction with prediction ----------------
  task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    int set, way, victim, n, wb0, rf0, exp_cycles;
    logic [31:0] tag, lad, exp_wb_addr;
    bit hit, exp_wb;
    set = int'((addr >> 5) % SETS);
    tag = addr >> 10;
    lad = addr & ~32'h1f;
    hit = 0; way = 0; exp_wb = 0; exp_wb_addr = '0;
    for (int w = 0; w < WAYS; w++) if (m_valid[set][w] && m_tag[set][w] == tag) begin hit = 1; way = w; end
    if (!hit) begin
      victim = -1;
      for (int w = 0; w < WAYS; w++) if (victim < 0 && !m_valid[set][w]) victim = w;
      if (victim < 0) victim = m_ptr[set];
      exp_wb = m_valid[set][victim] && m_dirty[set][victim];
      exp_wb_addr = (m_tag[set][victim] << 10) | (32'(set) << 5);
      way = victim;
    end
    exp_cycles = hit ? 0 : (exp_wb ? 2*LAT + 3 : LAT + 3);
    wb0 = wb_addr_q.size();
    rf0 = rf_addr_q.size();
    @(negedge clk);
    p1_addr_i = addr; p1_data_i = wdata;
    p1_MemWrite_i = wr; p1_MemRead_i = !wr;
    #1;
    n = 0;
    while (p1_stall_o === 1'b1 && n < STALL_MAX) begin
      @(negedge clk); #1; n++;
    end
    check("stall_cycles", LINE_W'(n), LINE_W'(exp_cycles));
    if (!wr) begin
      last_rdata = p1_data_o;
      check("read_data", LINE_W'(p1_data_o), LINE_W'(arch_rd(addr)));
    end
    @(posedge clk); #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    check("wb_count", LINE_W'(wb_addr_q.size() - wb0), LINE_W'(exp_wb));
    if (exp_wb && wb_addr_q.size() > wb0) begin
      check("wb_addr", LINE_W'(wb_addr_q[wb0]), LINE_W'(exp_wb_addr));
      check("wb_data", wb_data_q[wb0], arch_line(exp_wb_addr));
    end
    if (!hit) begin
      check("refill_count", LINE_W'(rf_addr_q.size() - rf0), LINE_W'(1));
      if (rf_addr_q.size() > rf0) check("refill_addr", LINE_W'(rf_addr_q[rf0]), LINE_W'(lad));
      m_valid[set][way] = 1; m_dirty[set][way] = 0; m_tag[set][way] = tag;
      m_ptr[set] = (m_ptr[set] + 1) % WAYS;
    end
    if (wr) begin
      arch_w[addr & ~32'h3] = wdata;
      m_dirty[set][way] = 1;
    end
  endtask

  task automatic do_flush(output int nwb);
    logic [31:0] exp_q[$];
    int wb0, n, pulses;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_dirty[s][w]) exp_q.push_back((m_tag[s][w] << 10) | (32'(s) << 5));
    wb0 = wb_addr_q.size();
    @(negedge clk); flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    n = 0; pulses = 0;
    while (pulses == 0 && n < FLUSH_MAX) begin
      if (flush_done_o === 1'b1) pulses++;
      else begin @(negedge clk); n++; end
    end
    check("flush_done_seen", LINE_W'(pulses), LINE_W'(1));
    @(negedge clk);
    check("flush_done_width", LINE_W'(flush_done_o), LINE_W'(0));
    check("flush_idle_stall", LINE_W'(p1_stall_o), LINE_W'(0));
    nwb = wb_addr_q.size() - wb0;
    check("flush_wb_count", LINE_W'(nwb), LINE_W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < nwb; i++) begin
      check("flush_wb_addr", LINE_W'(wb_addr_q[wb0 + i]), LINE_W'(exp_q[i]));
      check("flush_wb_data", wb_data_q[wb0 + i], arch_line(exp_q[i]));
    end
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_dirty[s][w] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] l;
    int nwb, n, wb0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_enable", LINE_W'(mem_enable_o), LINE_W'(0));
    check("rst_mem_write",  LINE_W'(mem_write_o),  LINE_W'(0));
    check("rst_mem_addr",   LINE_W'(mem_addr_o),   LINE_W'(0));
    check("rst_mem_data",   mem_data_o,            LINE_W'(0));
    check("rst_flush_done", LINE_W'(flush_done_o), LINE_W'(0));
    check("rst_p1_data",    LINE_W'(p1_data_o),    LINE_W'(0));
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_stall", LINE_W'(p1_stall_o), LINE_W'(0));

    // Cold read, repeat read, write hit, read back
    do_op(0, 32'h40, '0);
    l = init_line(32'h40);
    check("cold_word0", LINE_W'(last_rdata), LINE_W'(l[31:0]));
    do_op(0, 32'h40, '0);
    do_op(1, 32'h44, 32'hDEADBEEF);
    do_op(0, 32'h44, '0);
    check("write_readback", LINE_W'(last_rdata), LINE_W'(32'hDEADBEEF));
    check("mem_not_written", LINE_W'(mem_word(32'h44)), LINE_W'(l[63:32]));

    // Set 2 conflict: fill way1, evict dirty way0
    do_op(0, 32'h040, '0);
    do_op(0, 32'h440, '0);
    do_op(0, 32'h040, '0);
    wb0 = wb_addr_q.size();
    do_op(0, 32'h840, '0);
    check("evict_addr", LINE_W'(wb_addr_q[wb0]), LINE_W'(32'h40));
    check("evict_word1", LINE_W'(mem_word(32'h44)), LINE_W'(32'hDEADBEEF));

    // Write miss then flush of everything dirty
    do_op(1, 32'h1000, 32'h12345678);
    l = init_line(32'h1000);
    check("wm_mem_unchanged", LINE_W'(mem_word(32'h1000)), LINE_W'(l[31:0]));
    do_op(0, 32'h1000, '0);
    do_flush(nwb);
    check("wm_after_flush", LINE_W'(mem_word(32'h1000)), LINE_W'(32'h12345678));

    // Dirty lines in sets 5 and 1 (written out of order), flush in set order
    do_op(1, 32'h20A4, 32'hA5A5_0005);
    do_op(1, 32'h2020, 32'hA5A5_0001);
    do_flush(nwb);
    check("flush_two_wbs", LINE_W'(nwb), LINE_W'(2));
    do_op(0, 32'h2020, '0);
    do_op(0, 32'h20A4, '0);

    // Reset during a write-back
    do_op(1, 32'h0C0, 32'hCAFE_00C0);
    do_op(0, 32'h4C0, '0);
    wb0 = wb_addr_q.size();
    @(negedge clk);
    p1_addr_i = 32'h8C0; p1_MemRead_i = 1'b1;
    n = 0;
    while (!(mem_enable_o === 1'b1 && mem_write_o === 1'b1) && n < STALL_MAX) begin
      @(negedge clk); n++;
    end
    check("rwb_started", LINE_W'(mem_enable_o & mem_write_o), LINE_W'(1));
    check("rwb_addr", LINE_W'(mem_addr_o), LINE_W'(32'h0C0));
    #2 rst = 1'b1;
    #1;
    check("rwb_enable_drop", LINE_W'(mem_enable_o), LINE_W'(0));
    p1_MemRead_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    check("rwb_no_write", LINE_W'(wb_addr_q.size() - wb0), LINE_W'(0));
    model_reset();
    arch_w.delete();
    do_op(0, 32'h8C0, '0);
    do_op(0, 32'h0C0, '0);

    // Randomized traffic
    for (int i = 0; i < 160; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
          (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 24) == 0) do_flush(nwb);
      do_op(1'($urandom_range(0, 1)), a, $urandom);
    end
    do_flush(nwb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
